// File: rtl/wb_protocol_monitor.sv
// ---------------------------------------------------------------------------
// wb_protocol_monitor
//
// Passive Wishbone B4 classic-cycle protocol checker. It watches one
// master/slave link and never drives the bus. Every observed cycle produces a
// violation vector that is registered as a one-cycle pulse and accumulated
// into sticky flags. The index of the first violation is latched, and transfer
// statistics (ack count, abort count, worst wait-state count) are kept.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wb_cyc_i .. wb_dat_i   observed master signals
//   wb_ack_o/err_o/rty_o   observed slave terminations (inputs here)
//   clr_i                  synchronous clear of sticky/first/counters
//   err_pulse_o            violations seen in the previous cycle
//   err_sticky_o           accumulated violations
//   first_err_o/_valid_o   index of the first violation
//   xfer_cnt_o             ack-terminated transfers (saturating)
//   abort_cnt_o            cycles aborted by cyc dropping (saturating)
//   wait_max_o             largest wait-state count seen at termination
//
// Check indices
//   0 STB_NO_CYC  1 MULTI_TERM  2 TERM_NO_REQ  3 UNSTABLE
//   4 STB_DROP    5 TIMEOUT     6 RST_ACTIVE
// ---------------------------------------------------------------------------
module wb_protocol_monitor #(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int          SW       = DW / 8,
  parameter int          TIMEOUT  = 256,
  parameter int          TW       = 16,
  parameter int          CNT_W    = 32,
  parameter logic [6:0]  CHK_MASK = 7'h7F
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [SW-1:0]    wb_sel_i,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic             wb_ack_o,
  input  logic             wb_err_o,
  input  logic             wb_rty_o,
  input  logic             clr_i,
  output logic [6:0]       err_pulse_o,
  output logic [6:0]       err_sticky_o,
  output logic [2:0]       first_err_o,
  output logic             first_err_valid_o,
  output logic [CNT_W-1:0] xfer_cnt_o,
  output logic [15:0]      abort_cnt_o,
  output logic [TW-1:0]    wait_max_o
);

  // Wait counter fires at TO_LAST and then parks at TO_HOLD, which can never
  // match TO_LAST again, so the timeout is reported once per request.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_HOLD = TW'(TIMEOUT);

  logic          req;
  logic          term;
  logic          pend_reg;
  logic [AW-1:0] snap_addr_reg;
  logic          snap_we_reg;
  logic [SW-1:0] snap_sel_reg;
  logic [DW-1:0] snap_dat_reg;
  logic [TW-1:0] wait_cnt_reg;
  logic [TW-1:0] wait_cnt_next;
  logic          rst_d_reg;
  logic          rst_flag_reg;
  logic [6:0]    raw;
  logic [6:0]    v;
  logic [2:0]    low_idx;
  logic          unstable;

  assign req  = wb_cyc_i & wb_stb_i;
  assign term = wb_ack_o | wb_err_o | wb_rty_o;

  // Write data only has to stay stable on writes; read data lines are free.
  assign unstable = (wb_addr_i != snap_addr_reg) ||
                    (wb_we_i   != snap_we_reg)   ||
                    (wb_sel_i  != snap_sel_reg)  ||
                    (snap_we_reg && (wb_dat_i != snap_dat_reg));

  always_comb begin
    raw    = '0;
    raw[0] = wb_stb_i & ~wb_cyc_i;
    raw[1] = (wb_ack_o & wb_err_o) | (wb_ack_o & wb_rty_o) | (wb_err_o & wb_rty_o);
    raw[2] = term & ~req;
    raw[3] = pend_reg & req & unstable;
    raw[4] = pend_reg & wb_cyc_i & ~wb_stb_i;
    raw[5] = req & ~term & (wait_cnt_reg == TO_LAST);
    // Reported in the first cycle after reset release.
    raw[6] = ~wb_rst_i & rst_d_reg & rst_flag_reg;
  end

  assign v = raw & CHK_MASK;

  // Lowest set bit of v wins as the first-error index.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!req || term) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != TO_HOLD) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  // Reset-phase activity tracker. This is deliberately outside the reset
  // domain: it must remember what happened while reset was held.
  always_ff @(posedge wb_clk_i) begin
    rst_d_reg <= wb_rst_i;
    if (wb_rst_i) begin
      if (!rst_d_reg) begin
        rst_flag_reg <= 1'b0;          // first reset cycle is exempt
      end else if (wb_cyc_i || wb_stb_i) begin
        rst_flag_reg <= 1'b1;
      end
    end else if (rst_d_reg) begin
      rst_flag_reg <= 1'b0;            // consumed by raw[6] this cycle
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pend_reg          <= 1'b0;
      snap_addr_reg     <= '0;
      snap_we_reg       <= 1'b0;
      snap_sel_reg      <= '0;
      snap_dat_reg      <= '0;
      wait_cnt_reg      <= '0;
      err_pulse_o       <= '0;
      err_sticky_o      <= '0;
      first_err_o       <= '0;
      first_err_valid_o <= 1'b0;
      xfer_cnt_o        <= '0;
      abort_cnt_o       <= '0;
      wait_max_o        <= '0;
    end else begin
      // pend is simply "requesting and not yet terminated" last cycle.
      pend_reg     <= req & ~term;
      wait_cnt_reg <= wait_cnt_next;
      if (req && !pend_reg) begin
        snap_addr_reg <= wb_addr_i;
        snap_we_reg   <= wb_we_i;
        snap_sel_reg  <= wb_sel_i;
        snap_dat_reg  <= wb_dat_i;
      end

      err_pulse_o <= v;

      if (clr_i) begin
        err_sticky_o      <= '0;
        first_err_o       <= '0;
        first_err_valid_o <= 1'b0;
        xfer_cnt_o        <= '0;
        abort_cnt_o       <= '0;
        wait_max_o        <= '0;
      end else begin
        err_sticky_o <= err_sticky_o | v;
        if (!first_err_valid_o && (v != '0)) begin
          first_err_o       <= low_idx;
          first_err_valid_o <= 1'b1;
        end
        if (req && wb_ack_o && !(&xfer_cnt_o)) begin
          xfer_cnt_o <= xfer_cnt_o + 1'b1;
        end
        // A pending request losing cyc is an abort, not a violation.
        if (pend_reg && !wb_cyc_i && !(&abort_cnt_o)) begin
          abort_cnt_o <= abort_cnt_o + 1'b1;
        end
        if (req && term && (wait_cnt_reg > wait_max_o)) begin
          wait_max_o <= wait_cnt_reg;
        end
      end
    end
  end

endmodule
